// File: rtl/sad_min_reader_if.sv
// sad_min_reader_if: handshake and data signals between the SAD reader and its
// surroundings.
//
//   start     : single-cycle search start pulse (to reader)
//   busy      : reader is in a search or holding a result (from reader)
//   in_valid  : in_sad carries a candidate SAD (to reader)
//   in_ready  : reader accepts a candidate this cycle (from reader)
//   in_sad    : candidate SAD, unsigned, SAD_W bits (to reader)
//   res_valid : result available (from reader)
//   res_ready : downstream takes the result (to reader)
//   res_sad   : minimum SAD found, THRESHOLD when nothing matched (from reader)
//   res_idx   : arrival index of the winning candidate (from reader)
//   res_found : at least one candidate was below THRESHOLD (from reader)
//
// IDX_W must match the IDX_W of the sad_min_reader instance it connects to.
// modport master : the side that feeds candidates and consumes the result
// modport slave  : the reader itself
interface sad_min_reader_if #(
  parameter int unsigned IDX_W = 4
);

  localparam int unsigned SAD_W = 10;

  logic             start;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [SAD_W-1:0] in_sad;
  logic             res_valid;
  logic             res_ready;
  logic [SAD_W-1:0] res_sad;
  logic [IDX_W-1:0] res_idx;
  logic             res_found;

  modport master (
    output start,
    output in_valid,
    output in_sad,
    output res_ready,
    input  busy,
    input  in_ready,
    input  res_valid,
    input  res_sad,
    input  res_idx,
    input  res_found
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_sad,
    input  res_ready,
    output busy,
    output in_ready,
    output res_valid,
    output res_sad,
    output res_idx,
    output res_found
  );

endinterface

// File: rtl/sad_min_reader.sv
// sad_min_reader: consumes NUM_CAND accumulated SAD values from the PE array,
// one per candidate in index order, and reports the smallest value below
// THRESHOLD together with its arrival index on a valid/ready result port.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset; aborts any search in progress
//   bus  : sad_min_reader_if.slave (start/busy, candidate stream, result)
//
// Parameters:
//   THRESHOLD : PE saturation level; SADs >= THRESHOLD never win
//   NUM_CAND  : candidates per search (>= 2)
//   IDX_W     : candidate index width, 2**IDX_W >= NUM_CAND; must match bus
//
// busy/in_ready/res_valid are decoded from the state register only, and the
// res_* data fields are registers, so no input reaches an output in the same
// cycle.
module sad_min_reader #(
  parameter int unsigned THRESHOLD = 500,
  parameter int unsigned NUM_CAND  = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  sad_min_reader_if.slave  bus
);

  localparam int unsigned SAD_W = 10;
  // One extra bit so the count can reach NUM_CAND without wrapping.
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [SAD_W-1:0] THRESH_SAD = SAD_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] count;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             found;

  logic [SAD_W-1:0] res_sad_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             res_found_q;

  logic             busy_d;
  logic             in_ready_d;
  logic             res_valid_d;

  logic             accept;
  logic             last_accept;
  logic             better;
  logic [SAD_W-1:0] upd_sad;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_found;

  // Handshake qualifiers; in_ready_d depends on state only.
  assign accept      = in_ready_d & bus.in_valid;
  assign last_accept = accept && (count == LAST_CNT);

  // Best-so-far after the current candidate. Strict compare keeps the lowest
  // index on ties, and best_sad starting at THRESHOLD rejects saturated SADs.
  always_comb begin
    better    = bus.in_sad < best_sad;
    upd_sad   = best_sad;
    upd_idx   = best_idx;
    upd_found = found;
    if (better) begin
      upd_sad   = bus.in_sad;
      upd_idx   = IDX_W'(count);
      upd_found = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (last_accept) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    busy_d      = 1'b0;
    in_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
      end
      SCAN: begin
        busy_d     = 1'b1;
        in_ready_d = 1'b1;
      end
      DONE: begin
        busy_d      = 1'b1;
        res_valid_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Search datapath and result registers. The result loads on the final
  // accept so that the last candidate takes part in the comparison; outside
  // of that edge the result holds, including through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      best_sad    <= '0;
      best_idx    <= '0;
      found       <= 1'b0;
      res_sad_q   <= '0;
      res_idx_q   <= '0;
      res_found_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            count    <= '0;
            best_sad <= THRESH_SAD;
            best_idx <= '0;
            found    <= 1'b0;
          end
        end
        SCAN: begin
          if (accept) begin
            count    <= count + CNT_W'(1);
            best_sad <= upd_sad;
            best_idx <= upd_idx;
            found    <= upd_found;
          end
          if (last_accept) begin
            res_sad_q   <= upd_sad;
            res_idx_q   <= upd_idx;
            res_found_q <= upd_found;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  assign bus.busy      = busy_d;
  assign bus.in_ready  = in_ready_d;
  assign bus.res_valid = res_valid_d;
  assign bus.res_sad   = res_sad_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_found = res_found_q;

endmodule

// File: tb/tb_sad_min_reader.sv
// tb_sad_min_reader: directed test of sad_min_reader with NUM_CAND=4, IDX_W=2,
// THRESHOLD=500. Inputs change 1 time unit after the rising edge and outputs
// are sampled at the same point, away from the active edge.
module tb_sad_min_reader;

  localparam int unsigned NC = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TH = 500;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;
  int   t0;

  logic [9:0] vec [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sad_min_reader_if #(.IDX_W(IW)) bus ();

  sad_min_reader #(
    .THRESHOLD (TH),
    .NUM_CAND  (NC),
    .IDX_W     (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one candidate and hold it until the reader takes it.
  task automatic feed(input logic [9:0] v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sad   = v;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res;
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("res_valid_wait", 32'(bus.res_valid), 32'd1);
  endtask

  // Full search over vec[], with an optional stall before candidate 2.
  task automatic run(input int stall_len, output int latency);
    int start_cyc;
    start_cyc = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_in_ready", 32'(bus.in_ready), 32'd1);
          check("stall_res_valid", 32'(bus.res_valid), 32'd0);
        end
      end
      feed(vec[i]);
    end
    check("in_ready_after_last", 32'(bus.in_ready), 32'd0);
    wait_res();
    latency = cyc - start_cyc;
  endtask

  task automatic check_res(input string tag, input int sad, input int idx, input int fnd);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_sad"},   32'(bus.res_sad),   32'(sad));
    check({tag, "_idx"},   32'(bus.res_idx),   32'(idx));
    check({tag, "_found"}, 32'(bus.res_found), 32'(fnd));
  endtask

  task automatic release_res;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("release_res_valid", 32'(bus.res_valid), 32'd0);
    check("release_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res_sad"},   32'(bus.res_sad),   32'd0);
    check({tag, "_res_idx"},   32'(bus.res_idx),   32'd0);
    check({tag, "_res_found"}, 32'(bus.res_found), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sad    = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Basic search; 1 start edge + 4 accept edges before res_valid shows.
    vec = '{10'd300, 10'd120, 10'd450, 10'd200};
    run(0, lat);
    check("basic_latency", 32'(lat), 32'(NC + 1));
    check_res("basic", 120, 1, 1);
    check("basic_busy", 32'(bus.busy), 32'd1);
    release_res();
    check("hold_res_sad_idle", 32'(bus.res_sad), 32'd120);
    check("hold_res_idx_idle", 32'(bus.res_idx), 32'd1);

    // Nothing below threshold.
    vec = '{10'd500, 10'd500, 10'd511, 10'd1023};
    run(0, lat);
    check_res("saturated", 500, 0, 0);
    release_res();

    // Ties plus a two-cycle stall; stall adds exactly 2 to the latency.
    vec = '{10'd80, 10'd80, 10'd40, 10'd40};
    run(2, lat);
    check("stall_latency", 32'(lat), 32'(NC + 3));
    check_res("ties", 40, 2, 1);

    // Backpressure: result stable while res_ready is low.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_res("bp", 40, 2, 1);
    end
    // Handshake with start in the same cycle: start is ignored.
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check("hs_start_busy", 32'(bus.busy), 32'd0);
    check("hs_start_res_valid", 32'(bus.res_valid), 32'd0);
    tick();
    check("hs_start_still_idle", 32'(bus.busy), 32'd0);

    // start held during SCAN has no effect on count or best.
    t0 = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("scan_start_busy", 32'(bus.busy), 32'd1);
    feed(10'd100);
    bus.start = 1'b1;
    feed(10'd50);
    feed(10'd60);
    feed(10'd70);
    bus.start = 1'b0;
    check("scan_start_latency", 32'(cyc - t0), 32'(NC + 1));
    check_res("scan_start", 50, 1, 1);
    release_res();

    // Win on the very last candidate.
    vec = '{10'd300, 10'd300, 10'd300, 10'd7};
    run(0, lat);
    check_res("last_wins", 7, 3, 1);
    release_res();

    // THRESHOLD-1 is a match, THRESHOLD and above are not.
    vec = '{10'd499, 10'd500, 10'd600, 10'd499};
    run(0, lat);
    check_res("edge_499", 499, 0, 1);
    release_res();

    // start with no input: SCAN waits indefinitely.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_stream_busy", 32'(bus.busy), 32'd1);
    check("idle_stream_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_stream_res_valid", 32'(bus.res_valid), 32'd0);

    // Abort after 2 of 4 accepts.
    feed(10'd5);
    feed(10'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort");

    // Fresh search with no carry-over from the aborted one.
    vec = '{10'd10, 10'd20, 10'd30, 10'd499};
    run(0, lat);
    check("fresh_latency", 32'(lat), 32'(NC + 1));
    check_res("fresh", 10, 0, 1);
    release_res();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
